// File: rtl/aegnn_pkg.sv
// rtl/aegnn_pkg.sv - shared graph-build constants, types and pixel-range check
package aegnn;

    localparam int TOT_PIXEL    = 12000;
    localparam int MAX_DS_RANGE = 25;
    localparam int NODE_W       = 16;
    localparam int PIX_W        = $clog2(TOT_PIXEL) + 2;
    localparam int PIX_ADDR_W   = $clog2(TOT_PIXEL);
    localparam int IDX_W        = $clog2(MAX_DS_RANGE);
    localparam int CNT_W        = $clog2(MAX_DS_RANGE + 1);

    typedef logic signed [PIX_W-1:0] pix_sidx_t;
    typedef logic [NODE_W-1:0]       node_id_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WAIT,
        S_EMIT,
        S_DONE
    } scan_state_e;

    localparam pix_sidx_t TOT_PIXEL_S = pix_sidx_t'(TOT_PIXEL);

    // Out-of-frame neighbors arrive as negative indices or indices past the frame end.
    function automatic logic pix_in_frame(input pix_sidx_t pix);
        return !pix[PIX_W-1] && (pix < TOT_PIXEL_S);
    endfunction

endpackage

// File: rtl/neighbor_scan.sv
// rtl/neighbor_scan.sv - walks a neighbor-pixel list and streams occupied node IDs
module neighbor_scan
    import aegnn::*;
(
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [MAX_DS_RANGE-1:0][PIX_W-1:0]   req_pixels,
    output logic                                 mem_rd_en,
    output logic [PIX_ADDR_W-1:0]                mem_rd_addr,
    input  logic [NODE_W:0]                      mem_rd_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NODE_W-1:0]                    out_node,
    output logic                                 done,
    output logic [CNT_W-1:0]                     done_count
);

    scan_state_e                          r_state;
    logic [MAX_DS_RANGE-1:0][PIX_W-1:0]   r_pixels;
    logic [IDX_W-1:0]                     r_index;
    logic [CNT_W-1:0]                     r_count;
    node_id_t                             r_node;

    scan_state_e                          w_next_state;
    pix_sidx_t                            w_entry;
    logic                                 w_entry_valid;
    logic                                 w_last;
    logic                                 w_occupied;
    logic                                 w_accept;
    logic                                 w_advance;

    assign w_entry       = pix_sidx_t'(r_pixels[r_index]);
    assign w_entry_valid = pix_in_frame(w_entry);
    assign w_last        = (r_index == IDX_W'(MAX_DS_RANGE - 1));
    assign w_occupied    = mem_rd_data[NODE_W];
    assign w_accept      = (r_state == S_IDLE) && req_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_pixels <= '0;
            r_index  <= '0;
            r_count  <= '0;
            r_node   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_pixels <= req_pixels;
                r_index  <= '0;
                r_count  <= '0;
            end
            if (w_advance) begin
                r_index <= r_index + IDX_W'(1);
            end
            // Read data is only meaningful in the cycle after the strobe, i.e. in WAIT.
            if ((r_state == S_WAIT) && w_occupied) begin
                r_node <= mem_rd_data[NODE_W-1:0];
            end
            if ((r_state == S_EMIT) && out_ready) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_advance    = 1'b0;
        req_ready    = 1'b0;
        mem_rd_en    = 1'b0;
        mem_rd_addr  = '0;
        out_valid    = 1'b0;
        out_node     = '0;
        done         = 1'b0;
        done_count   = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_entry_valid) begin
                    mem_rd_en    = 1'b1;
                    mem_rd_addr  = w_entry[PIX_ADDR_W-1:0];
                    w_next_state = S_WAIT;
                end else if (w_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_advance = 1'b1;
                end
            end
            S_WAIT: begin
                if (w_occupied) begin
                    w_next_state = S_EMIT;
                end else if (w_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_advance    = 1'b1;
                    w_next_state = S_SCAN;
                end
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_node  = r_node;
                if (out_ready) begin
                    if (w_last) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_next_state = S_SCAN;
                    end
                end
            end
            S_DONE: begin
                done         = 1'b1;
                done_count   = r_count;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_neighbor_scan.sv
// tb/tb_neighbor_scan.sv - directed self-checking bench for neighbor_scan
module tb_neighbor_scan;
    import aegnn::*;

    typedef logic [MAX_DS_RANGE-1:0][PIX_W-1:0] list_t;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 req_valid;
    logic                 req_ready;
    list_t                req_pixels;
    logic                 mem_rd_en;
    logic [PIX_ADDR_W-1:0] mem_rd_addr;
    logic [NODE_W:0]      mem_rd_data = '0;
    logic                 out_valid;
    logic                 out_ready;
    logic [NODE_W-1:0]    out_node;
    logic                 done;
    logic [CNT_W-1:0]     done_count;

    logic [NODE_W:0]      occ_mem [0:TOT_PIXEL-1];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_seen = 0;
    int last_done_count = 0;
    int done_cyc = 0;
    int accept_cyc = 0;
    int rd_q[$];
    int out_q[$];

    neighbor_scan dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pixels (req_pixels),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_node   (out_node),
        .done       (done),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Occupancy memory: one-cycle registered read.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= occ_mem[mem_rd_addr];
        else           mem_rd_data <= '0;
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (mem_rd_en) rd_q.push_back(int'(mem_rd_addr));
            if (out_valid && out_ready) out_q.push_back(int'(out_node));
            if (done) begin
                done_seen       <= done_seen + 1;
                last_done_count <= int'(done_count);
                done_cyc        <= cyc;
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rd_q.delete();
        out_q.delete();
    endtask

    task automatic send_list(input list_t lst);
        @(posedge clk); #1;
        req_pixels = lst;
        req_valid  = 1'b1;
        @(negedge clk);
        check("accept_ready", int'(req_ready), 1);
        accept_cyc = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        int start = done_seen;
        while (done_seen == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_done_seen"}, (done_seen == start) ? 0 : 1, 1);
        repeat (3) @(posedge clk);
        check({tag, "_done_pulses"}, done_seen - start, 1);
    endtask

    list_t lst;
    int    n;
    int    start_done;
    logic  stable;

    initial begin
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_pixels = '0;
        out_ready  = 1'b1;
        for (int i = 0; i < TOT_PIXEL; i++) occ_mem[i] = '0;
        occ_mem[3012]  = {1'b1, 16'd7};
        occ_mem[0]     = {1'b1, 16'd3};
        occ_mem[11999] = {1'b1, 16'd9};
        occ_mem[500]   = {1'b0, 16'd55};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_mem_rd_en", int'(mem_rd_en), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_done_count", int'(done_count), 0);
        check("rst_out_node", int'(out_node), 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // (x=12, y=25): single occupied neighbor at 3012
        for (int i = 0; i < MAX_DS_RANGE; i++) lst[i] = '1;
        lst[0] = PIX_W'(3012);
        clear_mon();
        send_list(lst);
        wait_done("t1", 200);
        check("t1_reads", rd_q.size(), 1);
        check("t1_addr", rd_q[0], 3012);
        check("t1_outs", out_q.size(), 1);
        check("t1_node", out_q[0], 7);
        check("t1_count", last_done_count, 1);
        check("t1_latency", done_cyc - accept_cyc, 28);

        // all entries out of frame, mixing -1 and TOT_PIXEL
        for (int i = 0; i < MAX_DS_RANGE; i++) lst[i] = (i % 2 == 0) ? '1 : PIX_W'(TOT_PIXEL);
        clear_mon();
        send_list(lst);
        @(negedge clk);
        check("t2_busy_ready", int'(req_ready), 0);
        wait_done("t2", 200);
        check("t2_reads", rd_q.size(), 0);
        check("t2_count", last_done_count, 0);
        check("t2_latency", done_cyc - accept_cyc, MAX_DS_RANGE + 1);

        // frame corners 0 and TOT_PIXEL-1
        for (int i = 0; i < MAX_DS_RANGE; i++) lst[i] = '1;
        lst[0] = PIX_W'(0);
        lst[1] = PIX_W'(11999);
        clear_mon();
        send_list(lst);
        wait_done("t3", 200);
        check("t3_reads", rd_q.size(), 2);
        check("t3_addr0", rd_q[0], 0);
        check("t3_addr1", rd_q[1], 11999);
        check("t3_outs", out_q.size(), 2);
        check("t3_node0", out_q[0], 3);
        check("t3_node1", out_q[1], 9);
        check("t3_count", last_done_count, 2);

        // same list, downstream stalls the first emit
        clear_mon();
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_list(lst);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        check("t4_reach_emit", int'(out_valid), 1);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_node !== 16'd3 || out_valid !== 1'b1) stable = 1'b0;
        end
        check("t4_stable", int'(stable), 1);
        check("t4_stall_reads", rd_q.size(), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done("t4", 200);
        check("t4_reads", rd_q.size(), 2);
        check("t4_outs", out_q.size(), 2);
        check("t4_node0", out_q[0], 3);
        check("t4_node1", out_q[1], 9);
        check("t4_count", last_done_count, 2);

        // in-frame but unoccupied
        for (int i = 0; i < MAX_DS_RANGE; i++) lst[i] = '1;
        lst[3] = PIX_W'(500);
        clear_mon();
        send_list(lst);
        wait_done("t5", 200);
        check("t5_reads", rd_q.size(), 1);
        check("t5_addr", rd_q[0], 500);
        check("t5_outs", out_q.size(), 0);
        check("t5_count", last_done_count, 0);

        // reset while waiting for read data
        for (int i = 0; i < MAX_DS_RANGE; i++) lst[i] = '1;
        lst[0] = PIX_W'(3012);
        clear_mon();
        start_done = done_seen;
        send_list(lst);
        n = 0;
        while (mem_rd_en !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_saw_read", int'(mem_rd_en), 1);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("t6_idle_ready", int'(req_ready), 1);
        check("t6_no_valid", int'(out_valid), 0);
        check("t6_no_done", int'(done), 0);
        repeat (30) @(posedge clk);
        check("t6_no_done_pulse", done_seen - start_done, 0);
        check("t6_no_outs", out_q.size(), 0);
        check("t6_reads", rd_q.size(), 1);

        clear_mon();
        send_list(lst);
        wait_done("t7", 200);
        check("t7_reads", rd_q.size(), 1);
        check("t7_addr", rd_q[0], 3012);
        check("t7_node", out_q[0], 7);
        check("t7_count", last_done_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neighbor_scan.md
Name: neighbor_scan

Overview:
- Consumes the neighbor-pixel list produced by the graph-build address stage. That list is MAX_DS_RANGE signed linear pixel indices per event; an out-of-frame neighbor is encoded as a negative value or as a value >= TOT_PIXEL.
- Walks the list one entry at a time and reads the pixel-to-node occupancy memory for each in-frame entry.
- Streams the node IDs of occupied neighbors to the edge-construction stage over a valid/ready interface.
- Sits between get_neighbor_pixels and edge generation in the graph_build pipeline.

Parameters:
- TOT_PIXEL, 12000, frame pixel count (120 x 100); linear index = y*120 + x.
- MAX_DS_RANGE, 25, number of neighbor entries per request.
- NODE_W, 16, node ID width.
- PIX_W, $clog2(TOT_PIXEL)+2, signed width of one list entry.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  neighbor list valid
- req_ready  out  1  block can accept a list
- req_pixels  in  PIX_W x MAX_DS_RANGE  signed neighbor indices
- mem_rd_en  out  1  occupancy-memory read strobe
- mem_rd_addr  out  $clog2(TOT_PIXEL)  pixel address
- mem_rd_data  in  NODE_W+1  {occupied, node_id}; valid exactly 1 cycle after mem_rd_en
- out_valid  out  1  neighbor node valid
- out_ready  in  1  downstream accepts
- out_node  out  NODE_W  neighbor node ID
- done  out  1  one-cycle pulse: list fully scanned
- done_count  out  $clog2(MAX_DS_RANGE+1)  nodes emitted for this list; valid while done=1

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE, req_ready=1, all other outputs 0, index=0, count=0.
- Reset mid-scan aborts the list. No done pulse is produced, and a mem_rd_data returned after reset is ignored.
- States: IDLE, SCAN, WAIT, EMIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch all entries, set index=0 and count=0, go to SCAN.
  - req_ready=0 in every other state.
- SCAN, one entry examined per cycle:
  - Entry is invalid if its sign bit is set or it is >= TOT_PIXEL. For an invalid entry: if it is the last index go to DONE, else index++ and stay in SCAN.
  - Entry is valid: assert mem_rd_en=1 with mem_rd_addr = entry (truncated, unsigned), go to WAIT.
- WAIT:
  - Register mem_rd_data.
  - occupied=1: go to EMIT with out_node = node_id.
  - occupied=0: if last index go to DONE, else index++ and go to SCAN.
- EMIT:
  - out_valid=1; out_node stays stable until the handshake.
  - On out_ready: count++, then DONE if last index, else index++ and go to SCAN.
  - out_ready held low stalls the block indefinitely with no loss.
- DONE:
  - done=1 and done_count=count for exactly one cycle.
  - Next cycle IDLE.
  - A new request is accepted no earlier than the cycle after DONE.
- Latency:
  - Invalid entry: 1 cycle.
  - Valid, unoccupied entry: 2 cycles.
  - Occupied entry: 3 cycles when out_ready=1 throughout.
- Boundaries:
  - All entries invalid: done after MAX_DS_RANGE+1 cycles from accept, with done_count=0.
  - Index 0 and index TOT_PIXEL-1 are valid addresses.
  - The duplicate-free property of the list is upstream's responsibility; duplicates are emitted twice.
  - req_valid asserted while busy is held off by req_ready=0.
- Width rules:
  - The comparison against TOT_PIXEL is signed, at PIX_W bits.
  - count saturates cannot occur by construction, since count <= MAX_DS_RANGE.

Decomposition:
- Package aegnn holds:
  - TOT_PIXEL, MAX_DS_RANGE, NODE_W;
  - typedef pix_sidx_t (signed PIX_W) and node_id_t;
  - typedef scan_state_e;
  - function pix_in_frame(pix_sidx_t).
- No sub-module. The entry-validity check stays a package function so get_neighbor_pixels and this block share one definition.

Test Plan:
- List for (x=12, y=25): entry 0 = 3012, occupancy memory holds {1, 7} at 3012, all other entries -1. Expect one read at addr 3012, out_node=7, done_count=1.
- All 25 entries -1 or 12000. Expect no mem_rd_en, done at cycle 26 after accept, done_count=0.
- Entries 0 and 11999 valid and occupied with nodes 3 and 9. Expect reads at 0 and 11999, out_node sequence 3 then 9, done_count=2.
- Same list with out_ready low for 10 cycles during the first EMIT. Expect out_node=3 held stable, no extra read, final done_count=2.
- Valid but unoccupied entry 500. Expect a read at addr 500, no out_valid, done_count=0.
- rstn low mid-WAIT. Expect IDLE next cycle, req_ready=1, no done; a following request is scanned correctly.
